// File: rtl/decode_pkg.sv
// Shared types and constants for the RV32I(M) decode stage.
package decode_pkg;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;
  localparam logic [6:0] FUNCT7_MEXT = 7'h01;

  typedef enum logic [2:0] {
    alu_add, alu_sll, alu_sra, alu_sub, alu_xor, alu_srl, alu_or, alu_and
  } alu_ops_t;

  typedef enum logic [2:0] {
    cmp_beq = 3'b000, cmp_bne = 3'b001, cmp_blt = 3'b100,
    cmp_bge = 3'b101, cmp_bltu = 3'b110, cmp_bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    md_mul, md_mulh, md_mulhsu, md_mulhu, md_div, md_divu, md_rem, md_remu
  } md_funct3_t;

  typedef enum logic [1:0] {pcmux_pc_plus4, pcmux_alu_out, pcmux_alu_mod2} pcmux_t;
  typedef enum logic       {a1_rs1_out, a1_pc_out} alumux1_t;
  typedef enum logic [2:0] {a2_i_imm, a2_u_imm, a2_b_imm, a2_s_imm, a2_j_imm, a2_rs2_out} alumux2_t;
  typedef enum logic       {cmp_rs2_out, cmp_i_imm} cmpmux_t;
  typedef enum logic [3:0] {
    rf_alu_out, rf_br_en, rf_u_imm, rf_lw, rf_pc_plus4, rf_lb, rf_lbu, rf_lh, rf_lhu
  } regfilemux_t;

  typedef struct packed {
    logic [6:0]     opcode;
    alu_ops_t       aluop;
    branch_funct3_t cmpop;
    logic [2:0]     funct3;
    logic [6:0]     funct7;
    logic           load_regfile;
    logic           mem_read;
    logic           mem_write;
    pcmux_t         pcmux;
    alumux1_t       alumux1;
    alumux2_t       alumux2;
    cmpmux_t        cmpmux;
    regfilemux_t    regfilemux;
    logic [4:0]     rd;
  } rv32i_control_word_t;

  typedef struct packed {
    rv32i_control_word_t ctrl;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        rd_wr;
    logic        illegal;
    logic        is_muldiv;
    logic [2:0]  md_op;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] instruction;
    logic        trap;
  } decode_word_t;

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I(M) decoder: raw instruction + pc -> decode word.
module decode_comb
  import decode_pkg::*;
#(
  parameter int EN_MEXT = 0
) (
  input  logic [31:0]  instr_i,
  input  logic [31:0]  pc_i,
  output decode_word_t word_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  // Field defaults first, then per-opcode overrides; illegal entries are scrubbed of side effects.
  always_comb begin
    word_o                   = '0;
    word_o.ctrl.opcode       = opcode;
    word_o.ctrl.funct3       = funct3;
    word_o.ctrl.funct7       = funct7;
    word_o.ctrl.aluop        = alu_ops_t'(funct3);
    word_o.ctrl.cmpop        = branch_funct3_t'(funct3);
    word_o.ctrl.pcmux        = pcmux_pc_plus4;
    word_o.ctrl.alumux1      = a1_rs1_out;
    word_o.ctrl.alumux2      = a2_i_imm;
    word_o.ctrl.cmpmux       = cmp_rs2_out;
    word_o.ctrl.regfilemux   = rf_alu_out;
    word_o.ctrl.rd           = instr_i[11:7];
    word_o.rs1               = instr_i[19:15];
    word_o.rs2               = instr_i[24:20];
    word_o.uses_rs1          = 1'b1;
    word_o.pc_rdata          = pc_i;
    word_o.pc_wdata          = pc_i + 32'd4;
    word_o.instruction       = instr_i;

    unique case (opcode)
      OP_BR: begin
        word_o.ctrl.alumux1 = a1_pc_out;
        word_o.ctrl.alumux2 = a2_b_imm;
        word_o.ctrl.aluop   = alu_add;
        word_o.uses_rs2     = 1'b1;
        if (funct3 == 3'b010 || funct3 == 3'b011) word_o.illegal = 1'b1;
      end
      OP_LOAD: begin
        word_o.ctrl.aluop        = alu_add;
        word_o.ctrl.mem_read     = 1'b1;
        word_o.ctrl.load_regfile = 1'b1;
        unique case (funct3)
          3'b000:  word_o.ctrl.regfilemux = rf_lb;
          3'b001:  word_o.ctrl.regfilemux = rf_lh;
          3'b010:  word_o.ctrl.regfilemux = rf_lw;
          3'b100:  word_o.ctrl.regfilemux = rf_lbu;
          3'b101:  word_o.ctrl.regfilemux = rf_lhu;
          default: word_o.illegal = 1'b1;
        endcase
      end
      OP_STORE: begin
        word_o.ctrl.aluop     = alu_add;
        word_o.ctrl.alumux2   = a2_s_imm;
        word_o.ctrl.mem_write = 1'b1;
        word_o.uses_rs2       = 1'b1;
        if (funct3 > 3'b010) word_o.illegal = 1'b1;
      end
      OP_LUI: begin
        word_o.ctrl.load_regfile = 1'b1;
        word_o.ctrl.regfilemux   = rf_u_imm;
        word_o.uses_rs1          = 1'b0;
      end
      OP_AUIPC: begin
        word_o.ctrl.load_regfile = 1'b1;
        word_o.ctrl.aluop        = alu_add;
        word_o.ctrl.alumux1      = a1_pc_out;
        word_o.ctrl.alumux2      = a2_u_imm;
        word_o.uses_rs1          = 1'b0;
      end
      OP_JAL: begin
        word_o.ctrl.load_regfile = 1'b1;
        word_o.ctrl.aluop        = alu_add;
        word_o.ctrl.pcmux        = pcmux_alu_out;
        word_o.ctrl.alumux1      = a1_pc_out;
        word_o.ctrl.alumux2      = a2_j_imm;
        word_o.ctrl.regfilemux   = rf_pc_plus4;
        word_o.uses_rs1          = 1'b0;
      end
      OP_JALR: begin
        word_o.ctrl.load_regfile = 1'b1;
        word_o.ctrl.aluop        = alu_add;
        word_o.ctrl.pcmux        = pcmux_alu_mod2;
        word_o.ctrl.regfilemux   = rf_pc_plus4;
        if (funct3 != 3'b000) word_o.illegal = 1'b1;
      end
      OP_IMM: begin
        word_o.ctrl.load_regfile = 1'b1;
        unique case (funct3)
          3'b001: if (funct7 != FUNCT7_BASE) word_o.illegal = 1'b1;
          3'b101: begin
            if (funct7 == FUNCT7_ALT) word_o.ctrl.aluop = alu_sra;
            else if (funct7 != FUNCT7_BASE) word_o.illegal = 1'b1;
          end
          3'b010: begin
            word_o.ctrl.regfilemux = rf_br_en;
            word_o.ctrl.cmpmux     = cmp_i_imm;
            word_o.ctrl.cmpop      = cmp_blt;
          end
          3'b011: begin
            word_o.ctrl.regfilemux = rf_br_en;
            word_o.ctrl.cmpmux     = cmp_i_imm;
            word_o.ctrl.cmpop      = cmp_bltu;
          end
          default: ;
        endcase
      end
      OP_REG: begin
        word_o.ctrl.load_regfile = 1'b1;
        word_o.ctrl.alumux2      = a2_rs2_out;
        word_o.uses_rs2          = 1'b1;
        if (funct7 == FUNCT7_BASE) begin
          if (funct3 == 3'b010 || funct3 == 3'b011) begin
            word_o.ctrl.regfilemux = rf_br_en;
            word_o.ctrl.cmpop      = (funct3 == 3'b010) ? cmp_blt : cmp_bltu;
          end
        end else if (funct7 == FUNCT7_ALT) begin
          if (funct3 == 3'b000) word_o.ctrl.aluop = alu_sub;
          else if (funct3 == 3'b101) word_o.ctrl.aluop = alu_sra;
          else word_o.illegal = 1'b1;
        end else if (funct7 == FUNCT7_MEXT && EN_MEXT != 0) begin
          word_o.is_muldiv = 1'b1;
          word_o.md_op     = funct3;
        end else begin
          word_o.illegal = 1'b1;
        end
      end
      default: word_o.illegal = 1'b1;
    endcase

    if (word_o.illegal) begin
      word_o.ctrl.load_regfile = 1'b0;
      word_o.ctrl.mem_read     = 1'b0;
      word_o.ctrl.mem_write    = 1'b0;
      word_o.is_muldiv         = 1'b0;
    end
    word_o.rd_wr = word_o.ctrl.load_regfile & (word_o.ctrl.rd != 5'd0);
    word_o.trap  = word_o.illegal;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decoder feeding a DEPTH-entry FIFO with valid/ready, flush and retire order.
module decode_stage
  import decode_pkg::*;
#(
  parameter int EN_MEXT = 0,
  parameter int DEPTH   = 2,
  parameter int ORDER_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [31:0]        in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output decode_word_t       out_word,
  output logic [ORDER_W-1:0] out_order
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  decode_word_t       dec_word;
  decode_word_t       mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ORDER_W-1:0] order_q, order_d;
  logic               push, pop;

  decode_comb #(.EN_MEXT(EN_MEXT)) u_decode (
    .instr_i (in_instr),
    .pc_i    (in_pc),
    .word_o  (dec_word)
  );

  assign out_valid = (count_q != '0);
  assign in_ready  = ~rst & ((count_q < DEPTH_C) | (out_valid & out_ready));
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & in_ready & ~flush;
  assign out_word  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_order = order_q;

  // Next-state for pointers, occupancy and retire order; flush empties the buffer but a pop still retires.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    order_d  = order_q + ORDER_W'(pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (push && !pop) count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      order_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      order_q  <= order_d;
    end
  end

  // Buffer storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec_word;
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (M-extension off and on instances side by side).
module tb_decode_stage;
  import decode_pkg::*;

  logic         clk = 1'b0;
  logic         rst, in_valid, flush, out_ready;
  logic [31:0]  in_instr, in_pc;
  logic         in_ready, out_valid, in_ready_m, out_valid_m;
  decode_word_t out_word, out_word_m;
  logic [63:0]  out_order, out_order_m;
  int           checks = 0;
  int           errors = 0;

  decode_stage #(.EN_MEXT(0), .DEPTH(2), .ORDER_W(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_order(out_order));

  decode_stage #(.EN_MEXT(1), .DEPTH(2), .ORDER_W(64)) dut_m (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid_m), .out_ready(out_ready),
    .out_word(out_word_m), .out_order(out_order_m));

  always #5 clk = ~clk;

  // One line per popped entry.
  always @(negedge clk)
    if (!rst && out_valid && out_ready)
      $display("pop pc=%h instr=%h order=%0d illegal=%0b", out_word.pc_rdata, out_word.instruction, out_order, out_word.illegal);

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0; #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_instr = '0; in_pc = '0;
    step(); step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
    checks++; if (out_order !== 64'd0) begin errors++; $display("FAIL rst_order got %0d exp 0", out_order); end
    checks++; if (out_word !== '0) begin errors++; $display("FAIL rst_word got %h exp 0", out_word); end
    rst = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %0b exp 1", in_ready); end
  endtask

  task automatic test_add_sub();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h407302B3; in_pc = 32'h100;
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sub_valid got %0b exp 1", out_valid); end
    checks++; if (out_word.ctrl.aluop !== alu_sub) begin errors++; $display("FAIL sub_aluop got %0d exp 3", out_word.ctrl.aluop); end
    checks++; if ({out_word.ctrl.rd, out_word.rs1, out_word.rs2} !== {5'd5, 5'd6, 5'd7}) begin errors++; $display("FAIL sub_regs got %0d/%0d/%0d exp 5/6/7", out_word.ctrl.rd, out_word.rs1, out_word.rs2); end
    checks++; if (out_word.rd_wr !== 1'b1) begin errors++; $display("FAIL sub_rd_wr got %0b exp 1", out_word.rd_wr); end
    checks++; if (out_order !== 64'd0) begin errors++; $display("FAIL sub_order got %0d exp 0", out_order); end
    in_instr = 32'h003100B3; in_pc = 32'h104;
    step();
    checks++; if (out_word.ctrl.aluop !== alu_add) begin errors++; $display("FAIL add_aluop got %0d exp 0", out_word.ctrl.aluop); end
    checks++; if ({out_word.ctrl.rd, out_word.rs1, out_word.rs2} !== {5'd1, 5'd2, 5'd3}) begin errors++; $display("FAIL add_regs got %0d/%0d/%0d exp 1/2/3", out_word.ctrl.rd, out_word.rs1, out_word.rs2); end
    checks++; if (out_order !== 64'd1) begin errors++; $display("FAIL add_order got %0d exp 1", out_order); end
    checks++; if ({out_word.pc_rdata, out_word.pc_wdata} !== {32'h104, 32'h108}) begin errors++; $display("FAIL add_pc got %h/%h exp 104/108", out_word.pc_rdata, out_word.pc_wdata); end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain_valid got %0b exp 0", out_valid); end
    checks++; if (out_order !== 64'd2) begin errors++; $display("FAIL add_drain_order got %0d exp 2", out_order); end
  endtask

  task automatic test_mext();
    in_valid = 1'b1; in_instr = 32'h023100B3; in_pc = 32'h200;
    step();
    checks++; if ({out_word.illegal, out_word.rd_wr, out_word.trap} !== 3'b101) begin errors++; $display("FAIL mul_off got ill/rdwr/trap %0b%0b%0b exp 101", out_word.illegal, out_word.rd_wr, out_word.trap); end
    checks++; if ({out_word_m.is_muldiv, out_word_m.md_op, out_word_m.illegal} !== {1'b1, 3'b000, 1'b0}) begin errors++; $display("FAIL mul_on got md/op/ill %0b/%0d/%0b exp 1/0/0", out_word_m.is_muldiv, out_word_m.md_op, out_word_m.illegal); end
    checks++; if (out_word_m.rd_wr !== 1'b1) begin errors++; $display("FAIL mul_on_rd_wr got %0b exp 1", out_word_m.rd_wr); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_illegal_and_mem();
    in_valid = 1'b1; in_instr = 32'h00000000; in_pc = 32'h300;
    step();
    checks++; if ({out_word.illegal, out_word.ctrl.load_regfile, out_word.ctrl.mem_write} !== 3'b100) begin errors++; $display("FAIL ill_zero got %0b%0b%0b exp 100", out_word.illegal, out_word.ctrl.load_regfile, out_word.ctrl.mem_write); end
    in_instr = 32'h40009093;
    step();
    checks++; if ({out_word.illegal, out_word.ctrl.load_regfile, out_word.ctrl.mem_write, out_word.rd_wr} !== 4'b1000) begin errors++; $display("FAIL ill_slli got %0b%0b%0b%0b exp 1000", out_word.illegal, out_word.ctrl.load_regfile, out_word.ctrl.mem_write, out_word.rd_wr); end
    in_instr = 32'h0040A183;
    step();
    checks++; if ({out_word.ctrl.mem_read, out_word.ctrl.regfilemux, out_word.uses_rs2} !== {1'b1, rf_lw, 1'b0}) begin errors++; $display("FAIL lw_ctrl got rd/rfm/rs2 %0b/%0d/%0b exp 1/3/0", out_word.ctrl.mem_read, out_word.ctrl.regfilemux, out_word.uses_rs2); end
    in_instr = 32'h0020A423;
    step();
    checks++; if ({out_word.ctrl.mem_write, out_word.ctrl.alumux2, out_word.rd_wr, out_word.uses_rs2} !== {1'b1, a2_s_imm, 1'b0, 1'b1}) begin errors++; $display("FAIL sw_ctrl got wr/a2/rdwr/rs2 %0b/%0d/%0b/%0b exp 1/3/0/1", out_word.ctrl.mem_write, out_word.ctrl.alumux2, out_word.rd_wr, out_word.uses_rs2); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h0;
    step();
    in_pc = 32'h4;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_1 got %0b exp 1", in_ready); end
    step();
    in_pc = 32'h8;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %0b exp 0", in_ready); end
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_held_ready got %0b exp 0", in_ready); end
    checks++; if ({out_word.pc_rdata, out_order} !== {32'h0, 64'd0}) begin errors++; $display("FAIL bp_head0 got pc %h order %0d exp 0/0", out_word.pc_rdata, out_order); end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_pop_ready got %0b exp 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if ({out_word.pc_rdata, out_order} !== {32'h4, 64'd1}) begin errors++; $display("FAIL bp_head1 got pc %h order %0d exp 4/1", out_word.pc_rdata, out_order); end
    step();
    checks++; if ({out_word.pc_rdata, out_order} !== {32'h8, 64'd2}) begin errors++; $display("FAIL bp_head2 got pc %h order %0d exp 8/2", out_word.pc_rdata, out_order); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %0b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h20;
    step();
    in_pc = 32'h24;
    step();
    in_pc = 32'h28; out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_pop_valid got %0b exp 0", out_valid); end
    checks++; if (out_order !== 64'd1) begin errors++; $display("FAIL fl_pop_order got %0d exp 1", out_order); end
    in_valid = 1'b1; in_pc = 32'h30;
    step();
    in_pc = 32'h34; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if ({out_valid, out_order} !== {1'b0, 64'd1}) begin errors++; $display("FAIL fl_nopop got valid %0b order %0d exp 0/1", out_valid, out_order); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_dropped got %0b exp 0", out_valid); end
    in_valid = 1'b1; in_pc = 32'h38;
    step();
    checks++; if ({out_valid, out_word.pc_rdata, out_order} !== {1'b1, 32'h38, 64'd1}) begin errors++; $display("FAIL fl_refill got valid %0b pc %h order %0d exp 1/38/1", out_valid, out_word.pc_rdata, out_order); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_pc = 32'h3C; out_ready = 1'b0;
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    checks++; if ({out_valid, in_ready} !== 2'b00) begin errors++; $display("FAIL rm_during got valid %0b ready %0b exp 0/0", out_valid, in_ready); end
    rst = 1'b0; #1;
    checks++; if ({in_ready, out_order} !== {1'b1, 64'd0}) begin errors++; $display("FAIL rm_after got ready %0b order %0d exp 1/0", in_ready, out_order); end
    checks++; if (out_word !== '0) begin errors++; $display("FAIL rm_word got %h exp 0", out_word); end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mext();
    test_illegal_and_mem();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
